note_seq_ctrl: RTL and testbench

- Record/playback sequencer between the PS/2 note decoder output (8-bit note code, 0x00 = silence) and the audio tone generator's 8-bit note input.
- In IDLE and RECORD, passes the live keyboard note straight to the audio path.
- In RECORD, logs (note, duration) segments into an internal buffer.
- In PLAY, owns the audio path, replays the buffer with recorded timing and ignores the keyboard.

---
 rtl/note_seq_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_note_seq_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/note_seq_ctrl.sv
// Record/playback sequencer between the keyboard note decoder and the tone generator.
// Live notes pass through in IDLE/RECORD; RECORD logs (note, duration) segments, PLAY replays them.
module note_seq_ctrl #(
  parameter int TICK_DIV = 500000,
  parameter int DUR_W    = 8,
  parameter int DEPTH    = 64,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [7:0]        live_note,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  output logic [7:0]        note_out,
  output logic [1:0]        state,
  output logic              mem_full,
  output logic              done,
  output logic [ADDR_W:0]   entry_count
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RECORD    = 2'd1,
    S_PLAY_LOAD = 2'd2,
    S_PLAY      = 2'd3
  } state_e;

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ENTRY_W = 8 + DUR_W;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0]   DUR_MAX    = '1;
  localparam logic [DUR_W-1:0]   DUR_ONE    = DUR_W'(1);
  localparam logic [ADDR_W:0]    LAST_FILL  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]    CNT_ONE    = (ADDR_W+1)'(1);

  state_e               state_q, state_d;
  logic [7:0]           note_out_q, note_out_d;
  logic [7:0]           cur_note_q, cur_note_d;
  logic [DUR_W-1:0]     dur_q, dur_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]      entry_count_q, entry_count_d;
  logic                 mem_full_q, mem_full_d;
  logic                 done_q, done_d;

  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [ENTRY_W-1:0]   rd_data_q;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [ENTRY_W-1:0]   wr_data;

  logic                 tick;
  logic [DUR_W-1:0]     dur_inc;
  logic [DUR_W-1:0]     seg_dur;
  logic                 seg_change;
  logic                 dur_sat;
  logic                 rec_write;
  logic                 last_fill;
  logic [ADDR_W:0]      rd_next_cnt;
  logic                 play_last;
  logic                 seg_end;

  // Control contract: rec_start/play_start/stop are single-cycle pulses, stop wins over
  // rec_start which wins over play_start; done pulses for one cycle on each return to IDLE.
  assign tick        = (presc_q == PRESC_LAST);
  assign dur_inc     = dur_q + (tick ? DUR_ONE : '0);
  assign seg_dur     = (dur_inc == '0) ? DUR_ONE : dur_inc;
  assign seg_change  = (live_note != cur_note_q);
  assign dur_sat     = tick && (dur_inc == DUR_MAX);
  assign rec_write   = (state_q == S_RECORD) && (seg_change || dur_sat || stop);
  assign last_fill   = (entry_count_q == LAST_FILL);
  assign rd_next_cnt = {1'b0, rd_ptr_q} + CNT_ONE;
  assign play_last   = (rd_next_cnt == entry_count_q);
  assign seg_end     = tick && (dur_q == DUR_ONE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= S_IDLE;
      note_out_q    <= '0;
      cur_note_q    <= '0;
      dur_q         <= '0;
      presc_q       <= '0;
      rd_ptr_q      <= '0;
      entry_count_q <= '0;
      mem_full_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      note_out_q    <= note_out_d;
      cur_note_q    <= cur_note_d;
      dur_q         <= dur_d;
      presc_q       <= presc_d;
      rd_ptr_q      <= rd_ptr_d;
      entry_count_q <= entry_count_d;
      mem_full_q    <= mem_full_d;
      done_q        <= done_d;
    end
  end

  // Read address is the next pointer so the entry is ready during the PLAY_LOAD cycle.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= mem_q[rd_ptr_d];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!stop) begin
          if (rec_start) state_d = S_RECORD;
          else if (play_start && (entry_count_q != '0)) state_d = S_PLAY_LOAD;
        end
      end
      S_RECORD: begin
        if (rec_write && (stop || last_fill)) state_d = S_IDLE;
      end
      S_PLAY_LOAD: begin
        state_d = stop ? S_IDLE : S_PLAY;
      end
      S_PLAY: begin
        if (stop) state_d = S_IDLE;
        else if (seg_end) state_d = play_last ? S_IDLE : S_PLAY_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    note_out_d    = note_out_q;
    cur_note_d    = cur_note_q;
    dur_d         = dur_q;
    presc_d       = tick ? '0 : presc_q + PRESC_W'(1);
    rd_ptr_d      = rd_ptr_q;
    entry_count_d = entry_count_q;
    mem_full_d    = mem_full_q;
    done_d        = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = entry_count_q[ADDR_W-1:0];
    wr_data       = {cur_note_q, seg_dur};
    case (state_q)
      S_IDLE: begin
        note_out_d = live_note;
        presc_d    = '0;
        if (!stop && rec_start) begin
          entry_count_d = '0;
          mem_full_d    = 1'b0;
          cur_note_d    = live_note;
          dur_d         = '0;
        end else if (!stop && play_start) begin
          if (entry_count_q == '0) done_d = 1'b1;
          else rd_ptr_d = '0;
        end
      end
      S_RECORD: begin
        note_out_d = live_note;
        dur_d      = dur_inc;
        // A saturated duration closes the segment and reopens it with the same note.
        if (rec_write) begin
          wr_en         = 1'b1;
          entry_count_d = entry_count_q + CNT_ONE;
          cur_note_d    = live_note;
          dur_d         = '0;
          presc_d       = '0;
          if (last_fill) mem_full_d = 1'b1;
          if (stop || last_fill) done_d = 1'b1;
        end
      end
      S_PLAY_LOAD: begin
        if (stop) begin
          done_d = 1'b1;
        end else begin
          note_out_d = rd_data_q[ENTRY_W-1:DUR_W];
          dur_d      = rd_data_q[DUR_W-1:0];
          presc_d    = '0;
        end
      end
      S_PLAY: begin
        if (stop) begin
          done_d = 1'b1;
        end else if (tick) begin
          dur_d = dur_q - DUR_ONE;
          if (dur_q == DUR_ONE) begin
            if (play_last) done_d = 1'b1;
            else rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign note_out    = note_out_q;
  assign state       = state_q;
  assign mem_full    = mem_full_q;
  assign done        = done_q;
  assign entry_count = entry_count_q;

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Bench for note_seq_ctrl with TICK_DIV=4, DUR_W=4, DEPTH=4: directed record/playback
// scenarios, done events checked against an expected queue of {state, mem_full, entry_count}.
module tb_note_seq_ctrl;
  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 4;
  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 2;
  localparam int W        = 2 + 1 + ADDR_W + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        live_note;
  logic              rec_start;
  logic              play_start;
  logic              stop;
  logic [7:0]        note_out;
  logic [1:0]        state;
  logic              mem_full;
  logic              done;
  logic [ADDR_W:0]   entry_count;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  note_seq_ctrl #(.TICK_DIV(TICK_DIV), .DUR_W(DUR_W), .DEPTH(DEPTH)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .live_note   (live_note),
    .rec_start   (rec_start),
    .play_start  (play_start),
    .stop        (stop),
    .note_out    (note_out),
    .state       (state),
    .mem_full    (mem_full),
    .done        (done),
    .entry_count (entry_count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_done(input logic [1:0] st, input logic mf, input logic [ADDR_W:0] ec);
    exp_q.push_back({st, mf, ec});
  endtask

  // scoreboard monitor: every done pulse must match the oldest expected event
  always @(negedge clk) begin : mon_blk
    logic [W-1:0] e;
    if (done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected actual=%0h required=no_done", {state, mem_full, entry_count});
      end else begin
        e = exp_q.pop_front();
        if ({state, mem_full, entry_count} !== e) begin
          failures++;
          $display("FAIL done_event actual=%0h required=%0h", {state, mem_full, entry_count}, e);
        end
      end
    end
  end

  // stimulus
  initial begin
    int cnt;
    reset = 1'b1; rec_start = 1'b0; play_start = 1'b0; stop = 1'b0; live_note = 8'h00;
    step_n(3);
    chk("rst_note_out", 32'(note_out), 'h00);
    chk("rst_state", 32'(state), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_entry_count", 32'(entry_count), 0);
    chk("rst_mem_full", 32'(mem_full), 0);

    reset = 1'b0; live_note = 8'h1C;
    step();
    chk("idle_passthru", 32'(note_out), 'h1C);
    chk("idle_state", 32'(state), 0);

    // record {1C,3},{1B,2}
    rec_start = 1'b1; step(); rec_start = 1'b0;
    chk("rec_enter", 32'(state), 1);
    step_n(12);
    chk("rec_no_write_yet", 32'(entry_count), 0);
    live_note = 8'h1B; step();
    chk("rec_passthru", 32'(note_out), 'h1B);
    chk("rec_first_write", 32'(entry_count), 1);
    step_n(7);
    stop = 1'b1; expect_done(2'd0, 1'b0, 3'd2); step(); stop = 1'b0;
    chk("rec_stop_state", 32'(state), 0);
    chk("rec_stop_count", 32'(entry_count), 2);

    // playback with keyboard activity that must be ignored
    live_note = 8'h2A; play_start = 1'b1; step(); play_start = 1'b0;
    chk("play_load_state", 32'(state), 2);
    chk("play_load_hold", 32'(note_out), 'h2A);
    expect_done(2'd0, 1'b0, 3'd2);
    for (int k = 1; k <= 22; k++) begin
      live_note = 8'(8'h40 + k);
      step();
      chk($sformatf("play_note_%0d", k), 32'(note_out), (k <= 13) ? 'h1C : 'h1B);
      if (k == 1) chk("play_state", 32'(state), 3);
    end
    chk("play_end_state", 32'(state), 0);
    live_note = 8'h33; step();
    chk("play_end_resume", 32'(note_out), 'h33);

    // fill the buffer: fourth write ends the recording, fifth change is dropped
    live_note = 8'h10; rec_start = 1'b1; step(); rec_start = 1'b0;
    step_n(2);
    for (int n = 1; n <= 3; n++) begin
      live_note = 8'(8'h10 + n);
      step_n(2);
    end
    chk("fill_count_3", 32'(entry_count), 3);
    live_note = 8'h14; expect_done(2'd0, 1'b1, 3'd4); step();
    chk("fill_state", 32'(state), 0);
    chk("fill_mem_full", 32'(mem_full), 1);
    chk("fill_count", 32'(entry_count), 4);
    live_note = 8'h15; step_n(2);
    chk("fill_fifth_dropped", 32'(entry_count), 4);

    // stop mid-PLAY
    play_start = 1'b1; step(); play_start = 1'b0;
    step_n(4);
    chk("midplay_state", 32'(state), 3);
    stop = 1'b1; expect_done(2'd0, 1'b1, 3'd4); step(); stop = 1'b0;
    chk("stop_play_state", 32'(state), 0);
    step();
    chk("stop_play_resume", 32'(note_out), 'h15);

    // 17 ticks of one note splits into {22,15},{22,2}
    live_note = 8'h22; rec_start = 1'b1; step(); rec_start = 1'b0;
    chk("sat_mem_full_cleared", 32'(mem_full), 0);
    step_n(70);
    chk("sat_write", 32'(entry_count), 1);
    stop = 1'b1; expect_done(2'd0, 1'b0, 3'd2); step(); stop = 1'b0;
    chk("sat_count", 32'(entry_count), 2);
    live_note = 8'h01; play_start = 1'b1; expect_done(2'd0, 1'b0, 3'd2); step(); play_start = 1'b0;
    cnt = 0;
    while (state != 2'd0 && cnt < 200) begin
      step();
      cnt++;
    end
    chk("sat_play_len", 32'(cnt), 70);
    chk("sat_play_note", 32'(note_out), 'h22);

    // rec_start beats play_start; stop beats rec_start
    live_note = 8'h05; rec_start = 1'b1; play_start = 1'b1; step();
    rec_start = 1'b0; play_start = 1'b0;
    chk("rec_wins_state", 32'(state), 1);
    chk("rec_wins_count", 32'(entry_count), 0);
    stop = 1'b1; expect_done(2'd0, 1'b0, 3'd1); step(); stop = 1'b0;
    chk("short_seg_count", 32'(entry_count), 1);
    stop = 1'b1; rec_start = 1'b1; step(); stop = 1'b0; rec_start = 1'b0;
    chk("stop_wins_state", 32'(state), 0);

    // play with an empty buffer after reset
    reset = 1'b1; step_n(2); reset = 1'b0;
    play_start = 1'b1; expect_done(2'd0, 1'b0, 3'd0); step(); play_start = 1'b0;
    chk("empty_play_state", 32'(state), 0);

    // reset mid-PLAY
    live_note = 8'h30; rec_start = 1'b1; step(); rec_start = 1'b0;
    step_n(5);
    stop = 1'b1; expect_done(2'd0, 1'b0, 3'd1); step(); stop = 1'b0;
    live_note = 8'h31; play_start = 1'b1; step(); play_start = 1'b0;
    step_n(3);
    chk("rstplay_state_before", 32'(state), 3);
    chk("rstplay_note_before", 32'(note_out), 'h30);
    reset = 1'b1; step();
    chk("rstplay_note_out", 32'(note_out), 'h00);
    chk("rstplay_state", 32'(state), 0);
    chk("rstplay_count", 32'(entry_count), 0);
    chk("rstplay_done", 32'(done), 0);
    reset = 1'b0; step_n(3);

    chk("pending_done_events", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
